// File: rtl/link_decoder_if.sv
// Byte-stream side and decoded-result side of the link decoder.
// The decoder attaches through the slave modport; the byte source/consumer uses master.
interface link_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       link_en;
    logic [1:0] dir2;
    logic       rcvdir;
    logic [5:0] seed_x_out;
    logic [5:0] seed_y_out;
    logic       seed_valid;
    logic       start_game;
    logic       con_error;

    modport master (
        output rx_data, rx_valid, link_en,
        input  dir2, rcvdir, seed_x_out, seed_y_out, seed_valid, start_game, con_error
    );

    modport slave (
        input  rx_data, rx_valid, link_en,
        output dir2, rcvdir, seed_x_out, seed_y_out, seed_valid, start_game, con_error
    );
endinterface

// File: rtl/link_decoder.sv
// Remote-link packet decoder: header / payload / XOR checksum framing,
// byte and link timeout supervision, and a sticky connection-error flag.
module link_decoder #(
    parameter int unsigned BYTE_TIMEOUT = 75_000,
    parameter int unsigned LINK_TIMEOUT = 75_000_000,
    parameter int unsigned MAX_ERR      = 3
) (
    input  logic          clk,
    input  logic          rst,
    link_decoder_if.slave bus
);
    localparam int unsigned BW = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned LW = $clog2(LINK_TIMEOUT + 1);
    localparam int unsigned EW = $clog2(MAX_ERR + 1);
    localparam logic [BW-1:0] BT_LAST = BW'(BYTE_TIMEOUT - 1);
    localparam logic [LW-1:0] LT_LAST = LW'(LINK_TIMEOUT - 1);
    localparam logic [EW-1:0] ERR_MAX = EW'(MAX_ERR);
    localparam logic [EW-1:0] ERR_SET = EW'(MAX_ERR - 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK} state_t;
    typedef enum logic [1:0] {H_DIR, H_SEED, H_START} hdr_t;

    state_t        r_state, w_state_nxt;
    hdr_t          r_hdr, w_hdr_in;
    logic          w_is_hdr;
    logic [1:0]    r_cnt;
    logic [7:0]    r_xor, r_b0, r_b1;
    logic [BW-1:0] r_byte_cnt;
    logic [LW-1:0] r_link_cnt;
    logic [EW-1:0] r_err_cnt;
    logic [1:0]    r_dir2;
    logic [5:0]    r_seed_x, r_seed_y;
    logic          r_rcvdir, r_seed_valid, r_start_game, r_con_error;
    logic          w_byte_to, w_link_to, w_take_hdr, w_pay_byte, w_last_pay, w_accept, w_bad;

    always_comb begin
        w_is_hdr = 1'b1;
        w_hdr_in = H_DIR;
        case (bus.rx_data)
            8'hA1:   w_hdr_in = H_DIR;
            8'hA2:   w_hdr_in = H_SEED;
            8'hA3:   w_hdr_in = H_START;
            default: w_is_hdr = 1'b0;
        endcase
    end

    // A byte arriving in the timeout cycle is re-read as a fresh header.
    assign w_byte_to  = (r_state != S_IDLE) && (r_byte_cnt == BT_LAST);
    assign w_link_to  = bus.link_en && (r_link_cnt == LT_LAST);
    assign w_take_hdr = bus.rx_valid && w_is_hdr && ((r_state == S_IDLE) || w_byte_to);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_take_hdr) begin
            w_state_nxt = (w_hdr_in == H_START) ? S_CHECK : S_PAYLOAD;
        end else if (w_byte_to) begin
            w_state_nxt = S_IDLE;
        end else if (bus.rx_valid) begin
            case (r_state)
                S_PAYLOAD: if (w_last_pay) w_state_nxt = S_CHECK;
                S_CHECK:   w_state_nxt = S_IDLE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_last_pay = (r_hdr == H_DIR) || (r_cnt == 2'd1);
        w_pay_byte = bus.rx_valid && !w_byte_to && (r_state == S_PAYLOAD);
        w_accept   = bus.rx_valid && !w_byte_to && (r_state == S_CHECK) && (bus.rx_data == r_xor);
        w_bad      = w_byte_to ||
                     (bus.rx_valid && (r_state == S_CHECK) && (bus.rx_data != r_xor));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr <= H_DIR;
            r_cnt <= '0;
            r_xor <= '0;
            r_b0  <= '0;
            r_b1  <= '0;
        end else if (w_take_hdr) begin
            r_hdr <= w_hdr_in;
            r_xor <= bus.rx_data;
            r_cnt <= '0;
        end else if (w_pay_byte) begin
            r_cnt <= r_cnt + 2'd1;
            r_xor <= r_xor ^ bus.rx_data;
            if (r_cnt == 2'd0) r_b0 <= bus.rx_data;
            else               r_b1 <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.rx_valid)  r_byte_cnt <= '0;
        else if (r_byte_cnt != BT_LAST) r_byte_cnt <= r_byte_cnt + 1'b1;

        if (rst || w_accept || !bus.link_en) r_link_cnt <= '0;
        else if (r_link_cnt != LT_LAST)      r_link_cnt <= r_link_cnt + 1'b1;

        if (rst || w_accept)                   r_err_cnt <= '0;
        else if (w_bad && r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir2       <= '0;
            r_seed_x     <= '0;
            r_seed_y     <= '0;
            r_rcvdir     <= 1'b0;
            r_seed_valid <= 1'b0;
            r_start_game <= 1'b0;
            r_con_error  <= 1'b0;
        end else begin
            r_rcvdir     <= 1'b0;
            r_seed_valid <= 1'b0;
            r_start_game <= 1'b0;
            if (w_accept) begin
                case (r_hdr)
                    H_DIR: begin
                        r_dir2   <= r_b0[1:0];
                        r_rcvdir <= 1'b1;
                    end
                    H_SEED: begin
                        r_seed_x     <= r_b0[5:0];
                        r_seed_y     <= r_b1[5:0];
                        r_seed_valid <= 1'b1;
                    end
                    default: r_start_game <= 1'b1;
                endcase
            end
            if (w_accept && r_hdr == H_START)
                r_con_error <= 1'b0;
            else if (w_link_to || (w_bad && r_err_cnt >= ERR_SET))
                r_con_error <= 1'b1;
        end
    end

    assign bus.dir2       = r_dir2;
    assign bus.rcvdir     = r_rcvdir;
    assign bus.seed_x_out = r_seed_x;
    assign bus.seed_y_out = r_seed_y;
    assign bus.seed_valid = r_seed_valid;
    assign bus.start_game = r_start_game;
    assign bus.con_error  = r_con_error;
endmodule
